// File: rtl/store_buffer_if.sv
// Core-side store/load signals and the memory write port of the store buffer.
// slave is the buffer's view; master is the view of the core and memory.
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             storeValid;
    logic [1:0]       storeSrc;
    logic [31:0]      storeAddress;
    logic [31:0]      storeData;
    logic             storeReady;
    logic             misaligned;

    logic             loadValid;
    logic [31:0]      loadAddress;
    logic             loadHazard;

    logic             memValid;
    logic [31:0]      memAddress;
    logic [31:0]      memWriteData;
    logic [3:0]       memByteEn;
    logic             memReady;

    logic [CNT_W-1:0] count;

    modport slave (
        input  storeValid, storeSrc, storeAddress, storeData,
        input  loadValid, loadAddress, memReady,
        output storeReady, misaligned, loadHazard,
        output memValid, memAddress, memWriteData, memByteEn, count
    );

    modport master (
        output storeValid, storeSrc, storeAddress, storeData,
        output loadValid, loadAddress, memReady,
        input  storeReady, misaligned, loadHazard,
        input  memValid, memAddress, memWriteData, memByteEn, count
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer: lane-positions right-aligned stores, queues them in
// program order and drains them to memory; flags loads hitting a pending word.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    store_buffer_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic             is_half;
    logic             is_word;
    logic             mis;
    logic             ready;
    logic             enq;
    logic             deq;
    logic             hazard;
    logic [DEPTH-1:0] occupied;

    function automatic logic [31:0] place_data(input logic [1:0] src,
                                               input logic [1:0] a,
                                               input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (src)
            2'b00:   r = {24'b0, d[7:0]} << {a, 3'b000};
            2'b01:   r = a[1] ? {d[15:0], 16'b0} : {16'b0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] place_be(input logic [1:0] src,
                                            input logic [1:0] a);
        logic [3:0] r;
        r = 4'b1111;
        case (src)
            2'b00:   r = 4'b0001 << a;
            2'b01:   r = a[1] ? 4'b1100 : 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    // Size code 2'b11 is treated as a word, so bit 1 alone selects word size.
    always_comb begin
        is_half = (sb.storeSrc == 2'b01);
        is_word = sb.storeSrc[1];
        mis     = sb.storeValid &
                  ((is_half & sb.storeAddress[0]) |
                   (is_word & (sb.storeAddress[1:0] != 2'b00)));
        ready   = (cnt < FULL);
        enq     = sb.storeValid & ready & ~mis;
        deq     = (cnt != '0) & sb.memReady;
    end

    // An entry is live when its distance from the head is below the count;
    // full/empty never rely on pointer equality.
    always_comb begin
        logic [PTR_W-1:0] offs;
        occupied = '0;
        hazard   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offs        = PTR_W'(i) - rd_ptr;
            occupied[i] = (CNT_W'(offs) < cnt);
            if (occupied[i] && (addr_q[i] == sb.loadAddress[31:2]))
                hazard = 1'b1;
        end
        hazard = hazard & sb.loadValid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (enq) begin
                addr_q[wr_ptr] <= sb.storeAddress[31:2];
                data_q[wr_ptr] <= place_data(sb.storeSrc, sb.storeAddress[1:0], sb.storeData);
                be_q[wr_ptr]   <= place_be(sb.storeSrc, sb.storeAddress[1:0]);
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign sb.storeReady   = ready;
    assign sb.misaligned   = mis;
    assign sb.loadHazard   = hazard;
    assign sb.memValid     = (cnt != '0);
    assign sb.memAddress   = {addr_q[rd_ptr], 2'b00};
    assign sb.memWriteData = data_q[rd_ptr];
    assign sb.memByteEn    = be_q[rd_ptr];
    assign sb.count        = cnt;
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based model.
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    ent_t q[$];

    store_buffer_if #(.DEPTH(DEPTH)) bus ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        bus.storeValid   = 1'b0;
        bus.storeSrc     = 2'b00;
        bus.storeAddress = '0;
        bus.storeData    = '0;
        bus.loadValid    = 1'b0;
        bus.loadAddress  = '0;
        bus.memReady     = 1'b0;
    endtask

    // Drive one cycle, check every output against the model, advance the model.
    task automatic step(input logic sv, input logic [1:0] src, input logic [31:0] addr,
                        input logic [31:0] dat, input logic lv, input logic [31:0] la,
                        input logic mr);
        int          nb;
        int          a;
        logic        mis_e, rdy_e, hz_e, enq_e, deq_e;
        logic [63:0] mask;
        ent_t        e;
        bus.storeValid   = sv;
        bus.storeSrc     = src;
        bus.storeAddress = addr;
        bus.storeData    = dat;
        bus.loadValid    = lv;
        bus.loadAddress  = la;
        bus.memReady     = mr;
        #1;
        nb    = (src == 2'b00) ? 1 : (src == 2'b01) ? 2 : 4;
        a     = int'(addr[1:0]);
        mis_e = sv && ((a % nb) != 0);
        rdy_e = (q.size() < DEPTH);
        hz_e  = 1'b0;
        if (lv)
            foreach (q[i])
                if (q[i].wa == la[31:2]) hz_e = 1'b1;
        chk("misaligned", 32'(bus.misaligned), 32'(mis_e));
        chk("storeReady", 32'(bus.storeReady), 32'(rdy_e));
        chk("loadHazard", 32'(bus.loadHazard), 32'(hz_e));
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("memValid", 32'(bus.memValid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("memAddress", bus.memAddress, {q[0].wa, 2'b00});
            chk("memWriteData", bus.memWriteData, q[0].d);
            chk("memByteEn", 32'(bus.memByteEn), 32'(q[0].be));
        end
        enq_e = sv && rdy_e && !mis_e;
        deq_e = (q.size() != 0) && mr;
        mask  = (64'd1 << (8 * nb)) - 64'd1;
        e.wa  = addr[31:2];
        e.d   = 32'(({32'b0, dat} & mask) << (8 * a));
        e.be  = 4'(((1 << nb) - 1) << a);
        @(posedge clk);
        if (deq_e) void'(q.pop_front());
        if (enq_e) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        q.delete();
        chk("rst memValid", 32'(bus.memValid), 32'd0);
        chk("rst count", 32'(bus.count), 32'd0);
        chk("rst storeReady", 32'(bus.storeReady), 32'd1);
        chk("rst memAddress", bus.memAddress, 32'd0);
        chk("rst memWriteData", bus.memWriteData, 32'd0);
        chk("rst memByteEn", 32'(bus.memByteEn), 32'd0);
        chk("rst loadHazard", 32'(bus.loadHazard), 32'd0);
        chk("rst misaligned", 32'(bus.misaligned), 32'd0);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle();
        @(negedge clk);
        do_reset();

        // byte store lands in the top lane
        step(1, 2'b00, 32'h1003, 32'h0000_00A5, 0, 0, 0);
        idle(); #1;
        chk("sb memValid", 32'(bus.memValid), 32'd1);
        chk("sb memAddress", bus.memAddress, 32'h1000);
        chk("sb memWriteData", bus.memWriteData, 32'hA500_0000);
        chk("sb memByteEn", 32'(bus.memByteEn), 32'h8);
        step(0, 2'b00, 0, 0, 0, 0, 1);
        chk("sb drained count", 32'(bus.count), 32'd0);
        chk("sb drained memValid", 32'(bus.memValid), 32'd0);

        // half then word, held head while memReady low
        step(1, 2'b01, 32'h2002, 32'h0000_BEEF, 0, 0, 0);
        step(1, 2'b10, 32'h2004, 32'h1234_5678, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0);
        chk("sh count", 32'(bus.count), 32'd2);
        chk("sh data", bus.memWriteData, 32'hBEEF_0000);
        chk("sh be", 32'(bus.memByteEn), 32'hC);
        step(0, 2'b00, 0, 0, 0, 0, 1);
        chk("sw data", bus.memWriteData, 32'h1234_5678);
        chk("sw be", 32'(bus.memByteEn), 32'hF);
        step(0, 2'b00, 0, 0, 0, 0, 1);

        // fill to full, then a fifth store with and without memReady
        for (int i = 0; i < DEPTH; i++)
            step(1, 2'b10, 32'h2100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 0, 0, 0);
        idle(); #1;
        chk("full storeReady", 32'(bus.storeReady), 32'd0);
        chk("full count", 32'(bus.count), 32'd4);
        step(1, 2'b10, 32'h2200, 32'h5555_5555, 0, 0, 0);
        chk("fifth rejected count", 32'(bus.count), 32'd4);
        step(1, 2'b10, 32'h2200, 32'h5555_5555, 0, 0, 1);
        for (int i = 0; i < DEPTH + 1; i++)
            step(0, 2'b00, 0, 0, 0, 0, 1);

        // load hazard against a pending word
        step(1, 2'b10, 32'h3000, 32'hDEAD_BEEF, 0, 0, 0);
        bus.loadValid = 1'b1; bus.loadAddress = 32'h3002; #1;
        chk("hazard hit", 32'(bus.loadHazard), 32'd1);
        bus.loadAddress = 32'h3004; #1;
        chk("hazard other word", 32'(bus.loadHazard), 32'd0);
        step(0, 2'b00, 0, 0, 1, 32'h3002, 1);
        bus.loadValid = 1'b1; bus.loadAddress = 32'h3002; #1;
        chk("hazard after drain", 32'(bus.loadHazard), 32'd0);

        // misaligned half and word are dropped
        bus.loadValid = 1'b0;
        bus.storeValid = 1'b1; bus.storeSrc = 2'b01; bus.storeAddress = 32'h4001; #1;
        chk("mis half", 32'(bus.misaligned), 32'd1);
        step(1, 2'b01, 32'h4001, 32'h1111, 0, 0, 0);
        step(1, 2'b10, 32'h4002, 32'h2222_2222, 0, 0, 0);
        step(1, 2'b11, 32'h4003, 32'h3333_3333, 0, 0, 0);
        chk("mis count", 32'(bus.count), 32'd0);

        // reset mid-drain discards everything
        for (int i = 0; i < DEPTH; i++)
            step(1, 2'b10, 32'h4100 + 32'(4 * i), 32'hAB00_0000 + 32'(i), 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 1);
        step(0, 2'b00, 0, 0, 0, 0, 1);
        idle();
        do_reset();
        for (int i = 0; i < 3; i++)
            step(0, 2'b00, 0, 0, 0, 0, 1);

        // randomized traffic within a small address window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 9) < 7),
                 2'($urandom),
                 32'h5000 + 32'($urandom_range(0, 31)),
                 $urandom,
                 1'($urandom),
                 32'h5000 + 32'($urandom_range(0, 31)),
                 ($urandom_range(0, 9) < 5));
        end
        for (int i = 0; i < DEPTH + 1; i++)
            step(0, 2'b00, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
